write_int_reg_file: RTL and testbench
=====================================

// Module: write_int_reg_file
// PURPOSE
//  Integer register file fed by the write-back stage (consumer end of the exe->write latch).
//  Commits write-back results into 31 GPRs (x0 hardwired to zero).
//  Serves two combinational decode read ports.
//  Keeps a retired-instruction counter and the last-retired PC for debug/trace.
// PARAMETERS
//  XLEN      32  data width of registers, write data and PCs
//  NREGS     32  architectural register count; address width = $clog2(NREGS) = 5
//  CNT_W     64  width of retired-instruction counter
// PORTS
//  clk_i                     in   1      single clock, all state on posedge
//  rst_i                     in   1      synchronous reset, active-high
//  write_int_write_data_i    in   XLEN   result from write-back stage
//  write_write_addr_i        in   5      destination register
//  write_int_write_enable_i  in   1      commit write this cycle
//  write_instruction_i       in   32     instruction in write-back (32'b0 = bubble)
//  write_pc_i                in   XLEN   PC of instruction in write-back
//  dec_read_addr_a_i         in   5      decode read port A address
//  dec_read_addr_b_i         in   5      decode read port B address
//  dec_read_data_a_o         out  XLEN   port A data, combinational
//  dec_read_data_b_o         out  XLEN   port B data, combinational
//  instret_o                 out  CNT_W  number of retired (non-bubble) instructions
//  last_pc_o                 out  XLEN   PC of most recently retired instruction
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): all GPRs <= 0, instret_o <= 0, last_pc_o <= 0.
//    Writes and retirements presented in the reset cycle are discarded.
//  - Write: at posedge, if !rst_i && enable && addr!=0 then reg[addr] <= data.
//    Addr 0 with enable=1 is a no-op; x0 always reads 0.
//  - Read: data_x_o = (addr_x==0) ? 0 : reg[addr_x]; no clock latency.
//    Both ports may read the same register.
//  - Write->read latency: 1 cycle (visible after the committing edge), unless bypass is enabled.
//  - Retire: at posedge, if !rst_i && write_instruction_i!=32'b0:
//    instret_o <= instret_o+1 and last_pc_o <= write_pc_i.
//    Retirement is independent of write enable (stores/branches still retire).
//  - Counter wraps modulo 2^CNT_W: all-ones +1 -> 0, with no flag.
//  - Simultaneous write+retire in one cycle: both take effect.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    A read port whose addr equals write_write_addr_i (nonzero) while enable=1 returns
//    write_int_write_data_i in the same cycle (write-through).
//    Bypass is suppressed while rst_i=1.
//  WB_BYPASS_EN undefined:
//    Reads return the pre-edge register contents.
//    Decode must stall one cycle on a RAW hazard against write-back.
// STRUCTURE
//  Shared package vi_pkg:
//    XLEN, REG_ADDR_W=5, BUBBLE_INSTR=32'b0, typedef logic [XLEN-1:0] word_t.
//  Sub-module retire_counter:
//    Holds instret and last_pc regs; inputs clk_i, rst_i, valid, pc.
//  Register array and read muxing stay in the top module.
// TESTING
//  1 Write x5=32'hDEADBEEF, enable=1; next cycle read A=5 -> 32'hDEADBEEF.
//  2 Write x0=32'hFFFFFFFF, enable=1; read A=0, B=0 -> both 32'h0.
//  3 Same cycle: write x7=32'h12345678, read A=7 (x7 previously 0):
//    with WB_BYPASS_EN -> 32'h12345678; without -> 0, then 32'h12345678 next cycle.
//  4 Present instrs 0x00000013, 0x0 (bubble), 0x00A00093 with PCs 0x0, 0x4, 0x8
//    -> instret_o=2, last_pc_o=0x8.
//  5 Fill x1..x31 with index values, assert rst_i mid-sequence with enable=1
//    -> every read 0, instret_o=0, last_pc_o=0; the write in the reset cycle is lost.
//  6 Force instret to all-ones via CNT_W=4 build, retire one instr -> instret_o=0.

Source files
------------

// File: rtl/vi_pkg.sv
// Shared definitions for the write-back register file slice:
// datapath width, register address width and the bubble encoding.
package vi_pkg;

  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] BUBBLE_INSTR = 32'b0;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter and last-retired PC for debug/trace.
// The counter wraps modulo 2^CNT_W silently.
module retire_counter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid,
  input  logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] instret,
  output logic [XLEN-1:0]  last_pc
);

  // Count each non-bubble instruction and remember its PC; reset wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret <= '0;
      last_pc <= '0;
    end else if (valid) begin
      instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      last_pc <= pc;
    end
  end

endmodule

// File: rtl/write_int_reg_file.sv
// Integer register file at the consumer end of the exe->write latch.
// x0 is hardwired to zero; two combinational decode read ports.
// Optional build macro WB_BYPASS_EN: write-through from the write-back
// port to the read ports in the same cycle (suppressed during reset).
// Without it, reads see pre-edge contents and decode stalls on RAW.
module write_int_reg_file
  import vi_pkg::*;
#(
  parameter int XLEN  = vi_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [XLEN-1:0]       write_int_write_data_i,
  input  logic [REG_ADDR_W-1:0] write_write_addr_i,
  input  logic                  write_int_write_enable_i,
  input  logic [31:0]           write_instruction_i,
  input  logic [XLEN-1:0]       write_pc_i,
  input  logic [REG_ADDR_W-1:0] dec_read_addr_a_i,
  input  logic [REG_ADDR_W-1:0] dec_read_addr_b_i,
  output logic [XLEN-1:0]       dec_read_data_a_o,
  output logic [XLEN-1:0]       dec_read_data_b_o,
  output logic [CNT_W-1:0]      instret_o,
  output logic [XLEN-1:0]       last_pc_o
);

  logic [XLEN-1:0] regs [NREGS];
  logic            commit;
  logic            retire;

  assign commit = write_int_write_enable_i && (write_write_addr_i != '0);
  assign retire = (write_instruction_i != BUBBLE_INSTR);

  // Commit write-back results; x0 is never written, reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[write_write_addr_i] <= write_int_write_data_i;
    end
  end

  // Read port A: x0 reads zero, optional same-cycle write-through.
  always_comb begin
    dec_read_data_a_o = '0;
    if (dec_read_addr_a_i != '0) begin
      dec_read_data_a_o = regs[dec_read_addr_a_i];
`ifdef WB_BYPASS_EN
      if (!rst_i && commit && (dec_read_addr_a_i == write_write_addr_i)) begin
        dec_read_data_a_o = write_int_write_data_i;
      end
`endif
    end
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    dec_read_data_b_o = '0;
    if (dec_read_addr_b_i != '0) begin
      dec_read_data_b_o = regs[dec_read_addr_b_i];
`ifdef WB_BYPASS_EN
      if (!rst_i && commit && (dec_read_addr_b_i == write_write_addr_i)) begin
        dec_read_data_b_o = write_int_write_data_i;
      end
`endif
    end
  end

  retire_counter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_retire (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid   (retire),
    .pc      (write_pc_i),
    .instret (instret_o),
    .last_pc (last_pc_o)
  );

endmodule

// File: tb/tb_write_int_reg_file.sv
// Directed bench for write_int_reg_file: default build plus a CNT_W=4
// instance sharing the same stimulus to exercise counter wrap.
module tb_write_int_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [63:0] instret;
  logic [31:0] last_pc;
  logic [31:0] data_a4;
  logic [31:0] data_b4;
  logic [3:0]  instret4;
  logic [31:0] last_pc4;

  int checks = 0;
  int failures = 0;
  bit bypass;

  always #5 clk = ~clk;

  write_int_reg_file dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .write_int_write_data_i   (wdata),
    .write_write_addr_i       (waddr),
    .write_int_write_enable_i (wen),
    .write_instruction_i      (instr),
    .write_pc_i               (pc),
    .dec_read_addr_a_i        (addr_a),
    .dec_read_addr_b_i        (addr_b),
    .dec_read_data_a_o        (data_a),
    .dec_read_data_b_o        (data_b),
    .instret_o                (instret),
    .last_pc_o                (last_pc)
  );

  write_int_reg_file #(.CNT_W(4)) dut4 (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .write_int_write_data_i   (wdata),
    .write_write_addr_i       (waddr),
    .write_int_write_enable_i (wen),
    .write_instruction_i      (instr),
    .write_pc_i               (pc),
    .dec_read_addr_a_i        (addr_a),
    .dec_read_addr_b_i        (addr_b),
    .dec_read_data_a_o        (data_a4),
    .dec_read_data_b_o        (data_b4),
    .instret_o                (instret4),
    .last_pc_o                (last_pc4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; instr = '0; pc = '0;
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    idle();
    addr_a = '0; addr_b = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    addr_a = 5'd5; addr_b = 5'd31;
    #1;
    chk("rst_instret", instret, 64'd0);
    chk("rst_last_pc", {32'd0, last_pc}, 64'd0);
    chk("rst_read_a", {32'd0, data_a}, 64'd0);
    chk("rst_read_b", {32'd0, data_b}, 64'd0);

    // T1: write x5, read next cycle
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    wen = 1'b0; addr_a = 5'd5;
    #1;
    chk("t1_x5", {32'd0, data_a}, 64'hDEADBEEF);

    // T2: write to x0 is a no-op
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; addr_a = 5'd0; addr_b = 5'd0;
    #1;
    chk("t2_x0_same_a", {32'd0, data_a}, 64'd0);
    step();
    wen = 1'b0;
    #1;
    chk("t2_x0_a", {32'd0, data_a}, 64'd0);
    chk("t2_x0_b", {32'd0, data_b}, 64'd0);

    // T3: same-cycle read of the register being written
    wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678; addr_a = 5'd7; addr_b = 5'd5;
    #1;
    chk("t3_same_cycle", {32'd0, data_a}, bypass ? 64'h12345678 : 64'd0);
    chk("t3_other_port", {32'd0, data_b}, 64'hDEADBEEF);
    step();
    wen = 1'b0;
    #1;
    chk("t3_next_cycle", {32'd0, data_a}, 64'h12345678);
    addr_b = 5'd7;
    #1;
    chk("t3_both_ports", {32'd0, data_b}, 64'h12345678);

    // T4: retirement with a bubble, plus simultaneous write+retire
    rst = 1'b1;
    step();
    rst = 1'b0;
    instr = 32'h00000013; pc = 32'h0;
    step();
    instr = 32'h0; pc = 32'h4;
    step();
    chk("t4_bubble_cnt", instret, 64'd1);
    chk("t4_bubble_pc", {32'd0, last_pc}, 64'h0);
    instr = 32'h00A00093; pc = 32'h8;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h55;
    step();
    idle();
    addr_a = 5'd9;
    #1;
    chk("t4_instret", instret, 64'd2);
    chk("t4_last_pc", {32'd0, last_pc}, 64'h8);
    chk("t4_write_retire", {32'd0, data_a}, 64'h55);

    // T5: fill x1..x31, then reset with a write pending
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 32'(i); instr = 32'h13; pc = 32'(i * 4);
      step();
    end
    idle();
    addr_a = 5'd1; addr_b = 5'd31;
    #1;
    chk("t5_fill_x1", {32'd0, data_a}, 64'd1);
    chk("t5_fill_x31", {32'd0, data_b}, 64'd31);
    chk("t5_fill_cnt", instret, 64'd33);
    rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 32'hAA; instr = 32'h13; pc = 32'h100;
    addr_a = 5'd3;
    #1;
    chk("t5_no_bypass_in_rst", {32'd0, data_a}, 64'd3);
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i); addr_b = 5'(31 - i);
      #1;
      chk($sformatf("t5_clr_a%0d", i), {32'd0, data_a}, 64'd0);
      chk($sformatf("t5_clr_b%0d", 31 - i), {32'd0, data_b}, 64'd0);
    end
    chk("t5_instret", instret, 64'd0);
    chk("t5_last_pc", {32'd0, last_pc}, 64'd0);

    // T6: wrap the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      instr = 32'h13; pc = 32'(32'h200 + i * 4);
      step();
    end
    chk("t6_cnt4_full", {60'd0, instret4}, 64'hF);
    chk("t6_cnt64_15", instret, 64'd15);
    instr = 32'h13; pc = 32'h300;
    step();
    idle();
    #1;
    chk("t6_cnt4_wrap", {60'd0, instret4}, 64'd0);
    chk("t6_cnt64_16", instret, 64'd16);
    chk("t6_last_pc", {32'd0, last_pc4}, 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
